melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Plays a fixed 16-entry melody by sequencing divider values into the tone generator and the note display. It steps a note ROM at a fixed beat rate and inserts a short silent gap at the end of every note. It supports play/pause, stop and loop. It sits between the debounced/one-pulsed button logic and the `note_div` consumers (buzzer divider, seven-segment note display).

## Interface
- `BEAT_CYCLES`, 25_000_000: clock cycles per beat (0.25 s at 100 MHz); legal range ≥ 4.
- `GAP_CYCLES`, 2_500_000: silent cycles at the end of each note; legal range 1 to BEAT_CYCLES-1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `play_pulse`  in  1  one-cycle pulse; start from IDLE, or toggle PLAY/GAP ↔ PAUSE.
- `stop_pulse`  in  1  one-cycle pulse; return to IDLE, index 0.
- `loop_en`  in  1  level; 1 = wrap to entry 0 after entry 15, 0 = stop.
- `note_div`  out  22  divider for the current note; 0 = silence.
- `state`  out  1  1 while in PLAY or GAP, else 0.
- `index`  out  4  ROM entry currently addressed.
- `done`  out  1  one-cycle pulse when the song ends with `loop_en`=0.

## Operation
- **ROM entries.** Each entry is {code[3:0], dur[1:0]}. Note length is (dur+1) beats.
- **Code → divider.**
  - 0: 0 (rest).
  - Low octave: 1→191570, 2→170648, 3→151515, 4→143266, 5→127551, 6→113636, 7→101215.
  - High octave: 8→95420, 9→85034, 10→75758, 11→71633, 12→63776, 13→56818, 14→50607.
  - 15: 0.
- **ROM contents** (index:code/beats):
  - 0:1/1, 1:1/1, 2:5/1, 3:5/1, 4:6/1, 5:6/1, 6:5/2, 7:4/1
  - 8:4/1, 9:3/1, 10:3/1, 11:2/1, 12:2/1, 13:1/2, 14:0/2, 15:8/2
- **States: IDLE, PLAY, GAP, PAUSE.** One note counter `cnt` counts cycles within the current entry. Its length is (dur+1)·BEAT_CYCLES, so it must be at least 27 bits at the default parameters.
- **IDLE.** `note_div`=0, `cnt`=0, `index`=0. On `play_pulse`, go to PLAY.
- **PLAY.** `note_div`=div(code[index]). `cnt` increments. When `cnt` = L−GAP_CYCLES−1, go to GAP. L is the entry length.
- **GAP.** `note_div`=0 and `cnt` increments. When `cnt`=L−1, `cnt`←0 and the block advances:
  - `index`<15: `index`+1, go to PLAY.
  - `index`=15 and `loop_en`=1: `index`←0, go to PLAY.
  - `index`=15 and `loop_en`=0: `index`←0, go to IDLE, `done`=1 for one cycle.
- **PAUSE.** `note_div`=0. `cnt` and `index` hold. The state saves whether it came from PLAY or GAP, using one resume bit. `play_pulse` returns to the saved state and continues counting from the frozen `cnt`.
- **`play_pulse` in PLAY or GAP** goes to PAUSE.
- **`stop_pulse`** in any state goes to IDLE with `index`=0 and `cnt`=0. It wins over a simultaneous `play_pulse`, and no `done` is issued.
- **`loop_en`** is sampled only at the entry-15 boundary.
- **Rest entries** (code 0) traverse PLAY/GAP normally with `note_div`=0 throughout and `state`=1.

## Timing
- All outputs are registered.
- **Reset values:** IDLE, `note_div`=0, `state`=0, `index`=0, `done`=0, `cnt`=0, resume bit=PLAY.
- **Start latency.** `play_pulse` sampled high in IDLE at edge k gives `state`=1 and `note_div`=191570 after edge k+1.
- **Per entry:** exactly (dur+1)·BEAT_CYCLES cycles, of which the last GAP_CYCLES show `note_div`=0.
- **Pause/resume** adds exactly the paused cycles. No cycle of the note is lost or repeated.
- **Reset mid-note** is asynchronous: outputs take their reset values immediately, with no `done`.
- **Full song** (no pauses) = 20·BEAT_CYCLES cycles.

## Test plan
All scenarios use BEAT_CYCLES=8, GAP_CYCLES=2.
- **Reset then play.** Assert `rst_n`=0, release, then pulse play. Required:
  - `note_div`=191570 for 6 cycles, then 0 for 2 cycles.
  - `index`=1, then 191570 again.
  - At `index`=2, 127551.
- **Two-beat entry.** At entry 6, `note_div`=127551 for 14 cycles, then 0 for 2.
- **Pause mid-note.** Pulse play after 3 cycles of entry 0, hold 10 cycles, pulse play again. Required:
  - `note_div`=0 and `index` frozen during the pause.
  - 3 further cycles of 191570, then the gap.
  - Entry total = 18 cycles of wall time.
- **End without loop** (`loop_en`=0). After 160 cycles: `done`=1 for one cycle, IDLE, `index`=0, `state`=0, `note_div`=0.
- **End with loop** (`loop_en`=1). After entry 15 (95420), `index`=0 and 191570 follow with no idle cycle, and `done` stays 0.
- **Stop/play collision.** Assert `stop_pulse` and `play_pulse` on the same cycle during entry 4. Required: IDLE next cycle, `index`=0, no `done`. A later play restarts at entry 0.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a fixed 16-entry note ROM at a fixed beat rate.
// Each entry ends with a short silent gap. The sequencer supports
// play/pause, stop and loop. All outputs are registered, so they follow the
// internal state by one clock.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_pulse,
    input  logic        stop_pulse,
    input  logic        loop_en,
    output logic [21:0] note_div,
    output logic        state,
    output logic [3:0]  index,
    output logic        done
);

    // The longest entry is four beats, so the counter must hold 4*BEAT_CYCLES.
    localparam int CNT_W = $clog2(4 * BEAT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LEN1  = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] LEN2  = CNT_W'(2 * BEAT_CYCLES);
    localparam logic [CNT_W-1:0] LEN3  = CNT_W'(3 * BEAT_CYCLES);
    localparam logic [CNT_W-1:0] LEN4  = CNT_W'(4 * BEAT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    // Song table: {code[3:0], dur[1:0]}; the entry lasts (dur+1) beats.
    function automatic logic [5:0] rom_entry(input logic [3:0] i);
        case (i)
            4'd0:    rom_entry = {4'd1, 2'd0};
            4'd1:    rom_entry = {4'd1, 2'd0};
            4'd2:    rom_entry = {4'd5, 2'd0};
            4'd3:    rom_entry = {4'd5, 2'd0};
            4'd4:    rom_entry = {4'd6, 2'd0};
            4'd5:    rom_entry = {4'd6, 2'd0};
            4'd6:    rom_entry = {4'd5, 2'd1};
            4'd7:    rom_entry = {4'd4, 2'd0};
            4'd8:    rom_entry = {4'd4, 2'd0};
            4'd9:    rom_entry = {4'd3, 2'd0};
            4'd10:   rom_entry = {4'd3, 2'd0};
            4'd11:   rom_entry = {4'd2, 2'd0};
            4'd12:   rom_entry = {4'd2, 2'd0};
            4'd13:   rom_entry = {4'd1, 2'd1};
            4'd14:   rom_entry = {4'd0, 2'd1};
            default: rom_entry = {4'd8, 2'd1};
        endcase
    endfunction

    // Note code to tone divider; codes 0 and 15 are silence.
    function automatic logic [21:0] code_to_div(input logic [3:0] code);
        case (code)
            4'd1:    code_to_div = 22'd191570;
            4'd2:    code_to_div = 22'd170648;
            4'd3:    code_to_div = 22'd151515;
            4'd4:    code_to_div = 22'd143266;
            4'd5:    code_to_div = 22'd127551;
            4'd6:    code_to_div = 22'd113636;
            4'd7:    code_to_div = 22'd101215;
            4'd8:    code_to_div = 22'd95420;
            4'd9:    code_to_div = 22'd85034;
            4'd10:   code_to_div = 22'd75758;
            4'd11:   code_to_div = 22'd71633;
            4'd12:   code_to_div = 22'd63776;
            4'd13:   code_to_div = 22'd56818;
            4'd14:   code_to_div = 22'd50607;
            default: code_to_div = 22'd0;
        endcase
    endfunction

    logic [1:0]       fsm, fsm_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       idx, idx_n;
    logic             resume_gap, resume_gap_n;
    logic             ending, end_evt;

    logic [5:0]       entry;
    logic [CNT_W-1:0] entry_len;
    logic [CNT_W-1:0] play_last;
    logic [CNT_W-1:0] gap_last;

    // Decode the current entry's length and its PLAY/GAP boundaries.
    always_comb begin
        entry = rom_entry(idx);
        case (entry[1:0])
            2'd0:    entry_len = LEN1;
            2'd1:    entry_len = LEN2;
            2'd2:    entry_len = LEN3;
            default: entry_len = LEN4;
        endcase
        play_last = entry_len - GAP_C - ONE;
        gap_last  = entry_len - ONE;
    end

    // Next-state logic: normal advance first, then pause, then stop overrides.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        fsm_n        = fsm;
        cnt_n        = cnt;
        idx_n        = idx;
        resume_gap_n = resume_gap;
        end_evt      = 1'b0;

        case (fsm)
            S_IDLE: begin
                cnt_n = '0;
                idx_n = 4'd0;
                if (play_pulse) fsm_n = S_PLAY;
            end
            S_PLAY: begin
                cnt_n = cnt + ONE;
                if (cnt == play_last) fsm_n = S_GAP;
            end
            S_GAP: begin
                if (cnt == gap_last) begin
                    cnt_n = '0;
                    if (idx != 4'd15) begin
                        idx_n = idx + 4'd1;
                        fsm_n = S_PLAY;
                    end else if (loop_en) begin
                        idx_n = 4'd0;
                        fsm_n = S_PLAY;
                    end else begin
                        idx_n   = 4'd0;
                        fsm_n   = S_IDLE;
                        end_evt = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                if (play_pulse) fsm_n = resume_gap ? S_GAP : S_PLAY;
            end
        endcase

        // The cycle carrying the pause pulse still counts toward the note, so
        // pausing lands on the advanced position and remembers where to resume.
        if ((fsm == S_PLAY || fsm == S_GAP) && play_pulse && fsm_n != S_IDLE) begin
            resume_gap_n = (fsm_n == S_GAP);
            fsm_n        = S_PAUSE;
        end

        if (stop_pulse) begin
            fsm_n        = S_IDLE;
            cnt_n        = '0;
            idx_n        = 4'd0;
            resume_gap_n = 1'b0;
            end_evt      = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= S_IDLE;
            cnt        <= '0;
            idx        <= 4'd0;
            resume_gap <= 1'b0;
            ending     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            fsm        <= fsm_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            resume_gap <= resume_gap_n;
            ending     <= end_evt;
        end
    end

    // Registered outputs derived from the current internal state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_div <= '0;
            state    <= 1'b0;
            index    <= 4'd0;
            done     <= 1'b0;
        end else begin
            note_div <= (fsm == S_PLAY) ? code_to_div(entry[5:2]) : 22'd0;
            state    <= (fsm == S_PLAY) || (fsm == S_GAP);
            index    <= idx;
            done     <= ending;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with BEAT_CYCLES=8, GAP_CYCLES=2.
// A song-level reference model (phase, entry, position in entry) predicts the
// outputs; directed tests also compare against fixed expected sequences.
module tb_melody_sequencer;

    localparam int BEAT = 8;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play_pulse = 1'b0;
    logic        stop_pulse = 1'b0;
    logic        loop_en = 1'b0;
    logic [21:0] note_div;
    logic        state;
    logic [3:0]  index;
    logic        done;

    int checks = 0;
    int errors = 0;

    melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_pulse (play_pulse),
        .stop_pulse (stop_pulse),
        .loop_en    (loop_en),
        .note_div   (note_div),
        .state      (state),
        .index      (index),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference data taken from the song description.
    int song_code [16] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 8};
    int song_beats[16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2, 2, 2};
    int code_div  [16] = '{0, 191570, 170648, 151515, 143266, 127551, 113636, 101215,
                           95420, 85034, 75758, 71633, 63776, 56818, 50607, 0};

    // Model: phase 0 = idle, 1 = running, 2 = paused; pos = cycles into entry.
    int          m_phase, m_idx, m_pos;
    bit          m_done_evt;
    logic [21:0] exp_note;
    logic        exp_state;
    logic [3:0]  exp_index;
    logic        exp_done;

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_pos = 0; m_done_evt = 0;
        exp_note = '0; exp_state = 0; exp_index = '0; exp_done = 0;
    endtask

    // Outputs visible after an edge reflect the model state before that edge.
    task automatic model_step(input bit p, input bit s, input bit lp);
        int len;
        len = song_beats[m_idx] * BEAT;
        exp_note   = (m_phase == 1 && m_pos < len - GAP) ? 22'(code_div[song_code[m_idx]]) : 22'd0;
        exp_state  = (m_phase == 1);
        exp_index  = 4'(m_idx);
        exp_done   = m_done_evt;
        m_done_evt = 0;
        if (s) begin
            m_phase = 0; m_idx = 0; m_pos = 0;
        end else if (m_phase == 0) begin
            if (p) begin m_phase = 1; m_pos = 0; end
        end else if (m_phase == 2) begin
            if (p) m_phase = 1;
        end else begin
            m_pos++;
            if (m_pos == len) begin
                m_pos = 0;
                if (m_idx == 15) begin
                    m_idx = 0;
                    if (!lp) begin m_phase = 0; m_done_evt = 1; end
                end else begin
                    m_idx++;
                end
            end
            if (p && m_phase == 1) m_phase = 2;
        end
    endtask

    // One clock with the given pulses; outputs are then sampled 1 ns after the edge.
    task automatic cycle(input bit p, input bit s);
        play_pulse = p;
        stop_pulse = s;
        @(posedge clk);
        model_step(p, s, loop_en);
        #1;
        play_pulse = 0;
        stop_pulse = 0;
    endtask

    task automatic restart();
        cycle(0, 1);
        cycle(0, 0);
        cycle(1, 0);
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({note_div, state, index, done} !== 28'd0) begin
            errors++;
            $display("FAIL reset_values: got note=%0d state=%0b idx=%0d done=%0b, want all 0",
                     note_div, state, index, done);
        end
        rst_n = 1;
        cycle(0, 0);
        checks++;
        if ({note_div, state, index, done} !== 28'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got note=%0d state=%0b idx=%0d done=%0b, want all 0",
                     note_div, state, index, done);
        end
    endtask

    task automatic test_start();
        logic [21:0] want;
        loop_en = 0;
        cycle(1, 0);
        for (int t = 1; t <= 17; t++) begin
            cycle(0, 0);
            checks++;
            if ({note_div, state, index, done} !== {exp_note, exp_state, exp_index, exp_done}) begin
                errors++;
                $display("FAIL start_model t=%0d: got note=%0d state=%0b idx=%0d done=%0b, want note=%0d state=%0b idx=%0d done=%0b",
                         t, note_div, state, index, done, exp_note, exp_state, exp_index, exp_done);
            end
            if (t <= 9 || t == 17) begin
                want = (t <= 6 || t == 9) ? 22'd191570 : (t == 17) ? 22'd127551 : 22'd0;
                checks++;
                if (note_div !== want || state !== 1'b1 || index !== 4'((t - 1) / 8)) begin
                    errors++;
                    $display("FAIL start_seq t=%0d: got note=%0d state=%0b idx=%0d, want note=%0d state=1 idx=%0d",
                             t, note_div, state, index, want, (t - 1) / 8);
                end
            end
        end
    endtask

    task automatic test_two_beat();
        int run_play, run_gap;
        run_play = 0; run_gap = 0;
        loop_en = 0;
        restart();
        for (int t = 1; t <= 64; t++) begin
            cycle(0, 0);
            checks++;
            if ({note_div, state, index, done} !== {exp_note, exp_state, exp_index, exp_done}) begin
                errors++;
                $display("FAIL two_beat_model t=%0d: got note=%0d idx=%0d, want note=%0d idx=%0d",
                         t, note_div, index, exp_note, exp_index);
            end
            if (index == 4'd6 && note_div == 22'd127551) run_play++;
            if (index == 4'd6 && note_div == 22'd0 && state) run_gap++;
        end
        checks++;
        if (run_play != 14 || run_gap != 2) begin
            errors++;
            $display("FAIL two_beat_len: got play=%0d gap=%0d, want play=14 gap=2", run_play, run_gap);
        end
    endtask

    task automatic test_end_no_loop();
        int dones;
        dones = 0;
        loop_en = 0;
        restart();
        for (int t = 1; t <= 163; t++) begin
            cycle(0, 0);
            checks++;
            if ({note_div, state, index, done} !== {exp_note, exp_state, exp_index, exp_done}) begin
                errors++;
                $display("FAIL end_model t=%0d: got note=%0d state=%0b idx=%0d done=%0b, want note=%0d state=%0b idx=%0d done=%0b",
                         t, note_div, state, index, done, exp_note, exp_state, exp_index, exp_done);
            end
            if (done) dones++;
            if (t == 160) begin
                checks++;
                if (state !== 1'b1 || done !== 1'b0 || index !== 4'd15) begin
                    errors++;
                    $display("FAIL end_last_cycle: got state=%0b done=%0b idx=%0d, want state=1 done=0 idx=15",
                             state, done, index);
                end
            end
            if (t == 161) begin
                checks++;
                if ({note_div, state, index, done} !== {22'd0, 1'b0, 4'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL end_done: got note=%0d state=%0b idx=%0d done=%0b, want note=0 state=0 idx=0 done=1",
                             note_div, state, index, done);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL end_done_count: got %0d pulses, want 1", dones);
        end
    endtask

    task automatic test_loop();
        int dones;
        dones = 0;
        loop_en = 1;
        restart();
        for (int t = 1; t <= 170; t++) begin
            cycle(0, 0);
            checks++;
            if ({note_div, state, index, done} !== {exp_note, exp_state, exp_index, exp_done}) begin
                errors++;
                $display("FAIL loop_model t=%0d: got note=%0d state=%0b idx=%0d done=%0b, want note=%0d state=%0b idx=%0d done=%0b",
                         t, note_div, state, index, done, exp_note, exp_state, exp_index, exp_done);
            end
            if (done) dones++;
            if (t == 158 || t == 161) begin
                checks++;
                if (note_div !== ((t == 158) ? 22'd95420 : 22'd191570) || state !== 1'b1 ||
                    index !== ((t == 158) ? 4'd15 : 4'd0)) begin
                    errors++;
                    $display("FAIL loop_wrap t=%0d: got note=%0d state=%0b idx=%0d", t, note_div, state, index);
                end
            end
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL loop_no_done: got %0d pulses, want 0", dones);
        end
        loop_en = 0;
    endtask

    task automatic test_pause();
        int played, total;
        bit frozen_ok;
        played = 0; total = 0; frozen_ok = 1;
        loop_en = 0;
        restart();
        for (int t = 1; t <= 19; t++) begin
            cycle(t == 3 || t == 13, 0);
            checks++;
            if ({note_div, state, index, done} !== {exp_note, exp_state, exp_index, exp_done}) begin
                errors++;
                $display("FAIL pause_model t=%0d: got note=%0d state=%0b idx=%0d, want note=%0d state=%0b idx=%0d",
                         t, note_div, state, index, exp_note, exp_state, exp_index);
            end
            if (index == 4'd0) total++;
            if (index == 4'd0 && note_div == 22'd191570) played++;
            if (t >= 4 && t <= 13 && (note_div !== 22'd0 || index !== 4'd0)) frozen_ok = 0;
        end
        checks++;
        if (!frozen_ok) begin
            errors++;
            $display("FAIL pause_frozen: note or index moved while paused");
        end
        checks++;
        if (played != 6 || total != 18) begin
            errors++;
            $display("FAIL pause_total: got played=%0d wall=%0d, want played=6 wall=18", played, total);
        end
    endtask

    task automatic test_stop_collision();
        loop_en = 0;
        restart();
        for (int t = 1; t <= 34; t++) cycle(0, 0);
        checks++;
        if (index !== 4'd4 || note_div !== 22'd113636) begin
            errors++;
            $display("FAIL stop_setup: got idx=%0d note=%0d, want idx=4 note=113636", index, note_div);
        end
        cycle(1, 1);
        for (int t = 0; t < 3; t++) begin
            cycle(0, 0);
            checks++;
            if ({note_div, state, index, done} !== {22'd0, 1'b0, 4'd0, 1'b0}) begin
                errors++;
                $display("FAIL stop_idle t=%0d: got note=%0d state=%0b idx=%0d done=%0b, want all 0",
                         t, note_div, state, index, done);
            end
        end
        cycle(1, 0);
        cycle(0, 0);
        checks++;
        if (note_div !== 22'd191570 || index !== 4'd0 || state !== 1'b1) begin
            errors++;
            $display("FAIL stop_restart: got note=%0d idx=%0d state=%0b, want 191570 0 1",
                     note_div, index, state);
        end
    endtask

    task automatic test_async_reset();
        loop_en = 0;
        restart();
        for (int t = 1; t <= 12; t++) cycle(0, 0);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({note_div, state, index, done} !== 28'd0) begin
            errors++;
            $display("FAIL async_reset: got note=%0d state=%0b idx=%0d done=%0b, want all 0",
                     note_div, state, index, done);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        cycle(1, 0);
        cycle(0, 0);
        checks++;
        if (note_div !== 22'd191570 || state !== 1'b1 || index !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_restart: got note=%0d state=%0b idx=%0d done=%0b",
                     note_div, state, index, done);
        end
    endtask

    task automatic test_random();
        bit p, s;
        for (int t = 0; t < 3000; t++) begin
            if (t % 64 == 0) loop_en = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 149) == 0);
            cycle(p, s);
            checks++;
            if ({note_div, state, index, done} !== {exp_note, exp_state, exp_index, exp_done}) begin
                errors++;
                $display("FAIL random_model t=%0d: got note=%0d state=%0b idx=%0d done=%0b, want note=%0d state=%0b idx=%0d done=%0b",
                         t, note_div, state, index, done, exp_note, exp_state, exp_index, exp_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_two_beat();
        test_end_no_loop();
        test_loop();
        test_pause();
        test_stop_collision();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
